// File: rtl/tc_serial_pkg.sv
// rtl/tc_serial_pkg.sv - shared types and sizing helpers for the TC serial word link
package tc_serial_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } rx_state_t;

  localparam int TC_DATA_W = 32;

  function automatic int bit_cnt_w(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/rx_holding_reg.sv
// rtl/rx_holding_reg.sv - valid/ready word holding register with sticky overrun detection
module rx_holding_reg #(
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_word,
  input  logic              i_ready,
  input  logic              i_ovr_clr,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_overrun
);

  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_overrun;
  logic              w_accept;
  logic              w_drop;

  // A word can be taken whenever the slot is empty or being drained on this same edge.
  assign w_accept = i_load & (~r_valid | i_ready);
  assign w_drop   = i_load & r_valid & ~i_ready;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_accept) begin
        r_data  <= i_word;
        r_valid <= 1'b1;
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end

      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (i_ovr_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/serial_in_parallel_out_rx.sv
// rtl/serial_in_parallel_out_rx.sv - TC link receiver: MSB-first deserializer with framing FSM
// Optional even-parity bit after the LSB is enabled by defining SIPO_PARITY_EN.
module serial_in_parallel_out_rx
  import tc_serial_pkg::*;
#(
  parameter int DATA_W = TC_DATA_W
) (
  input  logic              clk_out,
  input  logic              reset,
  input  logic              sin,
  input  logic              frame_sync,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_busy,
  output logic              rx_overrun,
  input  logic              ovr_clr,
  output logic              rx_perr
);

  localparam int CNT_W = bit_cnt_w(DATA_W);
`ifdef SIPO_PARITY_EN
  localparam int SH_W = DATA_W;
`else
  // Without parity the LSB is never stored: it comes straight from sin on the completing edge.
  localparam int SH_W = DATA_W - 1;
`endif
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  rx_state_t         r_state;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [SH_W-1:0]   r_shift;
  logic              r_busy;
  logic              w_complete;
  logic [DATA_W-1:0] w_word;
`ifdef SIPO_PARITY_EN
  logic              r_perr;
  logic              w_par_bad;

  assign w_complete = ~frame_sync & (r_state == PARITY);
  assign w_word     = r_shift;
  assign w_par_bad  = ^{r_shift, sin};
`else
  assign w_complete = ~frame_sync & (r_state == SHIFT) & (r_bit_cnt == LAST_CNT);
  assign w_word     = {r_shift, sin};
`endif

  always_ff @(posedge clk_out) begin
    if (reset) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_busy    <= 1'b0;
`ifdef SIPO_PARITY_EN
      r_perr    <= 1'b0;
`endif
    end else begin
      // A sync strobe always restarts the frame, even mid-word or on the completing edge.
      if (frame_sync) begin
        r_state   <= SHIFT;
        r_bit_cnt <= CNT_W'(1);
        r_shift   <= SH_W'(sin);
        r_busy    <= 1'b1;
      end else begin
        case (r_state)
          SHIFT: begin
            r_shift   <= SH_W'({r_shift, sin});
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            if (r_bit_cnt == LAST_CNT) begin
`ifdef SIPO_PARITY_EN
              r_state <= PARITY;
`else
              r_state   <= IDLE;
              r_bit_cnt <= '0;
              r_busy    <= 1'b0;
`endif
            end
          end
          PARITY: begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_busy    <= 1'b0;
          end
          default: begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_busy    <= 1'b0;
          end
        endcase
      end

`ifdef SIPO_PARITY_EN
      if (w_complete && w_par_bad) begin
        r_perr <= 1'b1;
      end else if (ovr_clr) begin
        r_perr <= 1'b0;
      end
`endif
    end
  end

  rx_holding_reg #(
    .DATA_W (DATA_W)
  ) u_hold (
    .i_clk     (clk_out),
    .i_reset   (reset),
    .i_load    (w_complete),
    .i_word    (w_word),
    .i_ready   (rx_ready),
    .i_ovr_clr (ovr_clr),
    .o_data    (rx_data),
    .o_valid   (rx_valid),
    .o_overrun (rx_overrun)
  );

  assign rx_busy = r_busy;
`ifdef SIPO_PARITY_EN
  assign rx_perr = r_perr;
`else
  assign rx_perr = 1'b0;
`endif

endmodule

// File: tb/tb_serial_in_parallel_out_rx.sv
// tb/tb_serial_in_parallel_out_rx.sv - directed vector bench for serial_in_parallel_out_rx
module tb_serial_in_parallel_out_rx;

  localparam int DW = 32;
`ifdef SIPO_PARITY_EN
  localparam int FLEN = DW + 1;
`else
  localparam int FLEN = DW;
`endif

  logic          clk_out = 1'b0;
  logic          reset = 1'b1;
  logic          sin = 1'b0;
  logic          frame_sync = 1'b0;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready = 1'b0;
  logic          rx_busy;
  logic          rx_overrun;
  logic          ovr_clr = 1'b0;
  logic          rx_perr;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [DW-1:0] word;
    logic [DW-1:0] exp_data;
    logic          exp_valid;
    logic          exp_ovr;
  } vec_t;

  vec_t vecs [5];

  serial_in_parallel_out_rx #(.DATA_W(DW)) dut (
    .clk_out    (clk_out),
    .reset      (reset),
    .sin        (sin),
    .frame_sync (frame_sync),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_busy    (rx_busy),
    .rx_overrun (rx_overrun),
    .ovr_clr    (ovr_clr),
    .rx_perr    (rx_perr)
  );

  always #5 clk_out = ~clk_out;

  task automatic tick();
    @(posedge clk_out);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bits(input logic [DW-1:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      frame_sync = (i == 0);
      sin        = w[DW-1-i];
      tick();
    end
    frame_sync = 1'b0;
    sin        = 1'b0;
  endtask

  // Full frame; p is the parity bit (ignored in the no-parity build), rdy_last raises rx_ready for the final edge.
  task automatic send_frame(input logic [DW-1:0] w, input logic p, input logic rdy_last);
    for (int i = 0; i < FLEN; i++) begin
      frame_sync = (i == 0);
      sin        = (i < DW) ? w[DW-1-i] : p;
      if (i == FLEN - 1 && rdy_last) rx_ready = 1'b1;
      tick();
    end
    frame_sync = 1'b0;
    sin        = 1'b0;
  endtask

  initial begin
    vecs[0] = '{32'hA5A5_1234, 32'hA5A5_1234, 1'b1, 1'b0};
    vecs[1] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b0};
    vecs[2] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0};
    vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[4] = '{32'h8000_0001, 32'h8000_0001, 1'b1, 1'b0};

    tick();
    tick();
    check("reset_data", rx_data, 0);
    check("reset_valid", rx_valid, 0);
    check("reset_busy", rx_busy, 0);
    check("reset_ovr", rx_overrun, 0);
    check("reset_perr", rx_perr, 0);
    reset = 1'b0;
    tick();

    rx_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      send_frame(vecs[k].word, ^vecs[k].word, 1'b0);
      check($sformatf("vec%0d_valid", k), rx_valid, vecs[k].exp_valid);
      check($sformatf("vec%0d_data", k), rx_data, vecs[k].exp_data);
      check($sformatf("vec%0d_ovr", k), rx_overrun, vecs[k].exp_ovr);
      check($sformatf("vec%0d_busy", k), rx_busy, 0);
      check($sformatf("vec%0d_perr", k), rx_perr, 0);
      tick();
      check($sformatf("vec%0d_consumed", k), rx_valid, 0);
    end

    rx_ready = 1'b0;
    send_frame(32'h0000_0001, 1'b1, 1'b0);
    check("ovr_first_valid", rx_valid, 1);
    check("ovr_first_data", rx_data, 32'h0000_0001);
    check("ovr_first_flag", rx_overrun, 0);
    send_frame(32'h8000_0000, 1'b1, 1'b0);
    check("ovr_second_valid", rx_valid, 1);
    check("ovr_second_data", rx_data, 32'h0000_0001);
    check("ovr_second_flag", rx_overrun, 1);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check("ovr_clr_flag", rx_overrun, 0);
    check("ovr_clr_data", rx_data, 32'h0000_0001);
    check("ovr_clr_valid", rx_valid, 1);

    send_frame(32'h8000_0000, 1'b1, 1'b1);
    check("simul_valid", rx_valid, 1);
    check("simul_data", rx_data, 32'h8000_0000);
    check("simul_ovr", rx_overrun, 0);
    tick();
    check("simul_drain_valid", rx_valid, 0);
    check("simul_drain_data", rx_data, 32'h8000_0000);

    send_bits(32'hFFFF_FFFF, 10);
    check("restart_partial_busy", rx_busy, 1);
    check("restart_partial_valid", rx_valid, 0);
    send_frame(32'h1357_9BDF, ^32'h1357_9BDF, 1'b0);
    check("restart_valid", rx_valid, 1);
    check("restart_data", rx_data, 32'h1357_9BDF);
    check("restart_ovr", rx_overrun, 0);
    tick();
    check("restart_once", rx_valid, 0);

    rx_ready = 1'b0;
    send_frame(32'h0F0F_0F0F, 1'b0, 1'b0);
    check("rst_held_valid", rx_valid, 1);
    send_bits(32'hCAFE_F00D, 20);
    check("rst_mid_busy", rx_busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_data", rx_data, 0);
    check("rst_valid", rx_valid, 0);
    check("rst_busy", rx_busy, 0);
    check("rst_ovr", rx_overrun, 0);
    check("rst_perr", rx_perr, 0);
    rx_ready = 1'b1;
    send_frame(32'hDEAD_BEEF, 1'b0, 1'b0);
    check("post_rst_valid", rx_valid, 1);
    check("post_rst_data", rx_data, 32'hDEAD_BEEF);
    tick();

`ifdef SIPO_PARITY_EN
    send_frame(32'h0000_0003, 1'b0, 1'b0);
    check("par_good_perr", rx_perr, 0);
    check("par_good_data", rx_data, 32'h0000_0003);
    tick();
    send_frame(32'h0000_0003, 1'b1, 1'b0);
    check("par_bad_perr", rx_perr, 1);
    check("par_bad_valid", rx_valid, 1);
    check("par_bad_data", rx_data, 32'h0000_0003);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check("par_clr_perr", rx_perr, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
